// File: rtl/zbt_port_arbiter.sv
// zbt_port_arbiter: three-requester round-robin arbiter for a pipelined ZBT SRAM port.
// Define ARB_PORT0_PRIORITY_EN to give port 0 fixed priority over ports 1/2.
module zbt_port_arbiter #(
   parameter int ADDR_W   = 19,
   parameter int DATA_W   = 36,
   parameter int READ_LAT = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0_flag,
   input  logic              req0_wr,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic              req1_flag,
   input  logic              req1_wr,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   input  logic              req2_flag,
   input  logic              req2_wr,
   input  logic [ADDR_W-1:0] req2_addr,
   input  logic [DATA_W-1:0] req2_wdata,
   output logic              done0,
   output logic              done1,
   output logic              done2,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_write,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_read,
   output logic              busy
);

   logic [2:0]        flag;
   logic [2:0]        wr;
   logic [2:0]        eligible;
   logic [2:0]        grant;
   logic [2:0]        outstanding;
   logic [2:0]        done_q;
   logic [2:0]        done_nx;
   logic [2:0]        rd_done;
   logic [1:0]        last_ptr;
   logic [1:0]        gport;
   logic              grant_any;
   logic              sel_wr;
   logic              rd_issue;
   logic              busy_nx;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [READ_LAT:0] rd_valid;
   logic [1:0]        rd_port [READ_LAT+1];

   assign flag     = {req2_flag, req1_flag, req0_flag};
   assign wr       = {req2_wr, req1_wr, req0_wr};
   // A port stays ineligible through its own done cycle.
   assign eligible = flag & ~outstanding;

`ifdef ARB_PORT0_PRIORITY_EN
   logic last12;

   always_comb begin
      grant = '0;
      if (eligible[0])
         grant[0] = 1'b1;
      else if (eligible[1] && eligible[2]) begin
         if (last12)
            grant[1] = 1'b1;
         else
            grant[2] = 1'b1;
      end else if (eligible[1])
         grant[1] = 1'b1;
      else if (eligible[2])
         grant[2] = 1'b1;
   end

   // Tracks which of ports 1/2 won last; 1 means port 2.
   always_ff @(posedge clock) begin
      if (reset)
         last12 <= 1'b1;
      else if (grant[1] || grant[2])
         last12 <= grant[2];
   end
`else
   logic [1:0] c0;
   logic [1:0] c1;
   logic [1:0] c2;

   assign c0 = (last_ptr == 2'd2) ? 2'd0 : last_ptr + 2'd1;
   assign c1 = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
   assign c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;

   always_comb begin
      grant = '0;
      if (eligible[c0])
         grant[c0] = 1'b1;
      else if (eligible[c1])
         grant[c1] = 1'b1;
      else if (eligible[c2])
         grant[c2] = 1'b1;
   end
`endif

   assign grant_any = |grant;

   always_comb begin
      gport = 2'd0;
      unique case (1'b1)
         grant[0]: gport = 2'd0;
         grant[1]: gport = 2'd1;
         grant[2]: gport = 2'd2;
         default:  gport = 2'd0;
      endcase
   end

   always_comb begin
      sel_wr    = req0_wr;
      sel_addr  = req0_addr;
      sel_wdata = req0_wdata;
      case (gport)
         2'd1: begin
            sel_wr    = req1_wr;
            sel_addr  = req1_addr;
            sel_wdata = req1_wdata;
         end
         2'd2: begin
            sel_wr    = req2_wr;
            sel_addr  = req2_addr;
            sel_wdata = req2_wdata;
         end
         default: ;
      endcase
   end

   assign rd_issue = grant_any & ~sel_wr;
   assign rd_done  = rd_valid[READ_LAT] ?
                     (3'b001 << rd_port[READ_LAT]) : 3'b000;
   // Write done and read done may coincide; they are always different ports.
   assign done_nx  = rd_done | (grant & {3{sel_wr}});
   assign busy_nx  = rd_issue | (|rd_valid[READ_LAT-1:0]);

   always_ff @(posedge clock) begin
      if (reset) begin
         last_ptr    <= 2'd2;
         outstanding <= '0;
         done_q      <= '0;
         mem_wr      <= 1'b0;
         mem_addr    <= '0;
         mem_write   <= '0;
         rdata       <= '0;
         busy        <= 1'b0;
         rd_valid    <= '0;
         for (int i = 0; i <= READ_LAT; i++)
            rd_port[i] <= 2'd0;
      end else begin
         if (grant_any) begin
            last_ptr  <= gport;
            mem_addr  <= sel_addr;
            mem_write <= sel_wdata;
         end
         mem_wr      <= grant_any & sel_wr;
         done_q      <= done_nx;
         outstanding <= (outstanding | grant) & ~done_q;
         busy        <= busy_nx;
         rd_valid    <= {rd_valid[READ_LAT-1:0], rd_issue};
         rd_port[0]  <= gport;
         for (int i = 1; i <= READ_LAT; i++)
            rd_port[i] <= rd_port[i-1];
         if (rd_valid[READ_LAT])
            rdata <= mem_read;
      end
   end

   assign done0 = done_q[0];
   assign done1 = done_q[1];
   assign done2 = done_q[2];

endmodule

// File: doc/zbt_port_arbiter.md
ZBT_PORT_ARBITER -- requirements
Module: zbt_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 19, SHALL set the ZBT address width in bits.
REQ-002 Parameter DATA_W, default 36, SHALL set the ZBT data width in bits.
REQ-003 Parameter READ_LAT, default 2, SHALL set the ZBT read latency in cycles, from address on mem_addr to valid mem_read.
REQ-004 Port clock, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Ports reqK_flag, input, 1, K=0..2: requester K holds this high until its doneK pulses.
REQ-007 Ports reqK_wr, input, 1: 1 = write access, 0 = read access; held stable while reqK_flag is high.
REQ-008 Ports reqK_addr, input, ADDR_W: access address; held stable while reqK_flag is high.
REQ-009 Ports reqK_wdata, input, DATA_W: write data; held stable while reqK_flag is high.
REQ-010 Ports doneK, output, 1: one-cycle pulse marking completion of requester K's access.
REQ-011 Port rdata, output, DATA_W: read data, valid in the cycle in which a read's doneK pulses.
REQ-012 Ports mem_addr (output, ADDR_W), mem_write (output, DATA_W), mem_wr (output, 1), mem_read (input, DATA_W): the ZBT port.
REQ-013 Port busy, output, 1: high while any read is in flight.

Function
REQ-014 Eligibility: a port SHALL be eligible when its flag is high and it has no access outstanding, its done cycle included.
- Consequence: a port is never re-granted for the same request.
REQ-015 Grants: at most one grant per cycle.
- Round-robin order starts at (last granted port + 1) mod 3.
- The last-granted pointer updates only on a grant.
REQ-016 Issue timing: for a grant decided in cycle G, mem_addr, mem_write and mem_wr SHALL be driven from registers in cycle G+1.
- When no grant is made, mem_wr is 0 and mem_addr/mem_write hold their last values.
REQ-017 Write completion: doneK SHALL pulse in cycle G+1, the same cycle mem_wr is high.
REQ-018 Read completion: mem_read SHALL be captured at cycle G+1+READ_LAT; rdata and doneK SHALL be valid in cycle G+2+READ_LAT.
- Read data and done are registered.
REQ-019 Read tracking: a READ_LAT+1 deep shift register of {valid, port id} SHALL track reads.
- Back-to-back reads from different ports are accepted every cycle.
- Done pulses occur in issue order.
REQ-020 Mixed traffic: a write may issue while reads are in flight.
- In one cycle, a write done (port X) and a read done (port Y, with Y not equal to X) SHALL both pulse.
REQ-021 Idle flags: a requester dropping its flag before done is illegal; the arbiter SHALL still complete the access and pulse done.
REQ-022 No access SHALL be issued when no port is eligible.
REQ-023 Outputs SHALL be glitch-free, driven from registers only.

Reset
REQ-024 While reset is high, all outputs SHALL be 0: doneK, mem_wr, mem_addr, mem_write, rdata, busy.
REQ-025 Reset SHALL clear the pointer to 2, so port 0 wins first, and SHALL clear all outstanding and in-flight state.
REQ-026 Reset mid-operation: in-flight reads SHALL be discarded with no doneK pulse afterwards, and the first grant SHALL be possible in the cycle after reset deasserts.

Configuration
REQ-027 Macro ARB_PORT0_PRIORITY_EN, when defined, SHALL make port 0 win whenever eligible, with round-robin applied between ports 1 and 2 only.
REQ-028 Without ARB_PORT0_PRIORITY_EN, pure three-way round-robin SHALL apply (REQ-015).

Verification
REQ-029 Single write: after reset, req0 writes addr 0x00010, data 0x00000ABCD -> mem_wr=1 with that addr/data one cycle after grant; done0 pulses in the same cycle, exactly once.
REQ-030 Read latency: memory preloaded with 0x123 at 0x00020, req1 reads 0x00020 -> done1 and rdata=0x123 exactly READ_LAT+2 cycles (4) after the grant cycle; busy is high in between.
REQ-031 Round-robin: all three flags held high with writes, each requester re-raising its flag the cycle after its done -> grant order 0,1,2,0,1,2 (without macro); each port receives 1/3 of mem_wr cycles over 30 cycles.
REQ-032 Priority macro: same stimulus with ARB_PORT0_PRIORITY_EN defined -> port 0 is granted every eligible cycle; ports 1 and 2 alternate in the remaining slots.
REQ-033 Pipelined reads: req0 and req2 read different addresses in consecutive grants -> done0 then done2 on consecutive cycles with correct rdata; a req1 write issued meanwhile pulses done1 without corrupting read data.
REQ-034 Reset mid-read: assert reset one cycle after a read issue -> no doneK in any later cycle; all outputs 0 during reset; normal grants resume the next cycle.
